hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Consumes the ID-stage decode outputs (rs1/rs2 addresses, rs1/rs2 hazard-on flags, rd, reg write-enable, load indication) plus the EX branch outcome and the data-memory stall.
- Keeps a shadow tag pipeline of in-flight writers and decides the per-cycle stage enables, bubbles, flushes and registered forwarding selects.
- Maintains saturating stall and flush performance counters.

Parameters:
- FWD_EN, 1, 1 = forwarding enabled; 0 = interlock on every RAW match in EX/MEM/WB.
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs1  in  5  rs1 address (inst[19:15])
- i_id_rs2  in  5  rs2 address (inst[24:20])
- i_id_rs1_hazard_on  in  1  instruction reads rs1
- i_id_rs2_hazard_on  in  1  instruction reads rs2
- i_id_rd  in  5  destination register
- i_id_reg_wren  in  1  instruction writes rd
- i_id_is_load  in  1  write-back source is memory
- i_ex_br_taken  in  1  EX redirects the PC (taken branch or jump)
- i_mem_stall  in  1  data memory not ready; freeze the whole pipe
- o_pc_en  out  1  PC update enable
- o_ifid_en  out  1  IF/ID register enable
- o_ifid_flush  out  1  IF/ID becomes NOP
- o_idex_flush  out  1  ID/EX loads a bubble
- o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB
- o_fwd_a_sel  out  2  operand A source for the instruction now in EX: 00 regfile, 01 MEM result, 10 WB result, 11 retired-write hold register
- o_fwd_b_sel  out  2  same for operand B
- o_stall_cnt  out  CNT_W  cycles with a load-use or interlock stall
- o_flush_cnt  out  CNT_W  taken-redirect flush events

Behaviour:
- Reset (async, i_reset_n=0):
  - Shadow entries ex/mem/wb are invalid.
  - fwd selects are 00; counters are 0.
  - State is RESET; all enables and flushes are 0.
- State machine:
  - RESET -> RUN on the first i_clk edge with i_reset_n=1.
  - In RESET, outputs are held as at reset.
  - In RUN, the priority rules below apply.
- Shadow entry fields: {valid, rd, wren, load}.
- match(s, r): s.valid && s.wren && s.rd == r && r != 0, gated by the matching hazard_on flag and i_id_valid.
- Priority in RUN, highest first:
  1. freeze: i_mem_stall=1.
     - All enables are 0 and all flushes are 0.
     - Shadow, fwd registers and counters hold.
     - A pending i_ex_br_taken is applied on the first unfrozen cycle.
  2. redirect: i_ex_br_taken=1.
     - pc_en=1, ifid_flush=1, idex_flush=1, pipe_en=1.
     - Shadow advances with a bubble into ex; fwd registers load 00.
     - flush_cnt increments. Any coincident stall is suppressed and not counted.
  3. stall:
     - Condition when FWD_EN=1: a match on shadow ex with ex.load=1.
     - Condition when FWD_EN=0: a match on ex, mem or wb.
     - pc_en=0, ifid_en=0, idex_flush=1, pipe_en=1.
     - Shadow advances with a bubble into ex; fwd registers load 00; stall_cnt increments.
  4. normal:
     - All enables are 1.
     - Shadow advances: wb<=mem, mem<=ex, ex<=ID fields, with valid = i_id_valid.
     - fwd registers load the per-operand value:
       - 01 if ex matches;
       - else 10 if mem matches;
       - else 11 if wb matches;
       - else 00.
     - Youngest producer wins.
     - When FWD_EN=0, the fwd registers stay 00.
- Latency:
  - Stall, flush and enable outputs are combinational from inputs and shadow state, same cycle.
  - fwd selects are registered and valid during the cycle the consumer occupies EX.
- rd = x0 never matches; hazard_on=0 never matches.
- Counters saturate at all-ones.
- Reset asserted mid-operation clears everything immediately (asynchronously). In-flight shadow entries are discarded.

Decomposition:
- Package hazard_pkg holds:
  - the fwd_sel_e enum: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10, FWD_HOLD=2'b11;
  - the shadow_tag_t struct {valid, rd[4:0], wren, load};
  - the ctrl_state_e enum {RESET, RUN}.
- One sub-module, hazard_shadow_pipe: the 3-entry tag shift register with advance and bubble-insert controls.

Test Plan:
- Reset then release:
  - First cycle after release: all enables 0, selects 00, counters 0.
  - Next cycle: pc_en=ifid_en=pipe_en=1.
- lw x5 followed by add x6,x5,x7 (rs1 hazard_on):
  - One cycle with pc_en=0, ifid_en=0, idex_flush=1.
  - Then the add enters EX with fwd_a_sel=10, fwd_b_sel=00; stall_cnt=1.
- add x3 then sub x4,x3,x3 back-to-back:
  - No stall; sub in EX sees fwd_a_sel=fwd_b_sel=01.
  - With one independent instruction between: 10. With two between: 11.
- Writer rd=x0 followed by a reader of x0: no stall, fwd 00.
- i_ex_br_taken=1 coincident with a load-use condition:
  - ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- i_mem_stall=1 for 3 cycles during a load-use:
  - All enables 0, counters and fwd selects frozen.
  - The stall is applied after release; stall_cnt increments by exactly 1.
  - Repeat the scenario with FWD_EN=0: an add x3 then a dependent reader stalls 3 cycles.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline sequencing controller.
//   fwd_sel_e    - operand source select for the instruction in EX
//   shadow_tag_t - per-stage record of an in-flight register writer
//   ctrl_state_e - controller state (RESET until the first live clock, then RUN)
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_HOLD = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wren;
    logic       load;
  } shadow_tag_t;

  typedef enum logic {
    RESET,
    RUN
  } ctrl_state_e;

  // Shadow stage indices: 0 is the youngest writer (EX), 2 the oldest (WB).
  localparam int NUM_STAGES = 3;
  localparam int STG_EX     = 0;
  localparam int STG_MEM    = 1;
  localparam int STG_WB     = 2;

  localparam shadow_tag_t TAG_BUBBLE = '0;

  // True when the staged instruction will write register r. x0 is hardwired
  // to zero, so a write to it never creates a dependency.
  function automatic logic tag_writes(input shadow_tag_t tag, input logic [4:0] r);
    return tag.valid && tag.wren && (tag.rd == r) && (r != 5'd0);
  endfunction

  // Youngest producer wins: EX beats MEM beats WB.
  function automatic fwd_sel_e fwd_pick(input logic [NUM_STAGES-1:0] hit);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (hit[STG_EX])       sel = FWD_MEM;
    else if (hit[STG_MEM]) sel = FWD_WB;
    else if (hit[STG_WB])  sel = FWD_HOLD;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/branch/memory-stall inputs and the stage control
// outputs of the hazard controller.
//   master - the pipeline side: drives i_* and consumes o_*
//   slave  - the hazard controller: consumes i_* and drives o_*
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             i_id_valid;
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  logic             i_id_rs1_hazard_on;
  logic             i_id_rs2_hazard_on;
  logic [4:0]       i_id_rd;
  logic             i_id_reg_wren;
  logic             i_id_is_load;
  logic             i_ex_br_taken;
  logic             i_mem_stall;

  logic             o_pc_en;
  logic             o_ifid_en;
  logic             o_ifid_flush;
  logic             o_idex_flush;
  logic             o_pipe_en;
  logic [1:0]       o_fwd_a_sel;
  logic [1:0]       o_fwd_b_sel;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_hazard_on, i_id_rs2_hazard_on,
           i_id_rd, i_id_reg_wren, i_id_is_load, i_ex_br_taken, i_mem_stall,
    input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_pipe_en,
           o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_hazard_on, i_id_rs2_hazard_on,
           i_id_rd, i_id_reg_wren, i_id_is_load, i_ex_br_taken, i_mem_stall,
    output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_pipe_en,
           o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_shadow_pipe.sv
// hazard_shadow_pipe: three-entry tag shift register mirroring the writers in
// EX, MEM and WB.
//   i_clk, i_reset_n - clock, asynchronous active-low reset (entries invalid)
//   advance          - shift: wb<=mem, mem<=ex, ex<=id_tag (or bubble)
//   bubble           - with advance, load an invalid tag into EX instead
//   id_tag           - writer record of the instruction leaving ID
//   stage_tag        - current EX/MEM/WB entries (index 0 = EX)
module hazard_shadow_pipe
  import hazard_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        advance,
  input  logic        bubble,
  input  shadow_tag_t id_tag,
  output shadow_tag_t stage_tag [NUM_STAGES]
);

  shadow_tag_t tag_reg  [NUM_STAGES];
  shadow_tag_t tag_next [NUM_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign tag_next[gi] = bubble ? TAG_BUBBLE : id_tag;
      end else begin : g_body
        assign tag_next[gi] = tag_reg[gi-1];
      end
      assign stage_tag[gi] = tag_reg[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_STAGES; i++) tag_reg[i] <= TAG_BUBBLE;
    end else if (advance) begin
      for (int i = 0; i < NUM_STAGES; i++) tag_reg[i] <= tag_next[i];
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
//   i_clk, i_reset_n - clock, asynchronous active-low reset
//   bus (slave)      - ID decode fields, EX redirect, memory stall in;
//                      PC/IF-ID/pipe enables, flushes, registered forwarding
//                      selects and saturating stall/flush counters out
// Parameters: FWD_EN (1 = forward, stall only on load-use; 0 = interlock on any
// RAW hit in EX/MEM/WB), CNT_W (counter width).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input logic         i_clk,
  input logic         i_reset_n,
  hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_state_e            state_reg, state_next;
  fwd_sel_e               fwd_a_reg, fwd_a_next;
  fwd_sel_e               fwd_b_reg, fwd_b_next;
  logic [CNT_W-1:0]       stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0]       flush_cnt_reg, flush_cnt_next;

  shadow_tag_t            id_tag;
  shadow_tag_t            stage_tag [NUM_STAGES];
  logic [NUM_STAGES-1:0]  hit_a, hit_b;
  logic                   rs1_used, rs2_used, raw_stall;
  logic                   shift_en, insert_bubble, stall_hit, flush_hit;
  logic                   pc_en, ifid_en, ifid_flush, idex_flush, pipe_en;

  assign id_tag = '{valid: bus.i_id_valid, rd: bus.i_id_rd,
                    wren: bus.i_id_reg_wren, load: bus.i_id_is_load};

  hazard_shadow_pipe u_shadow (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .advance   (shift_en),
    .bubble    (insert_bubble),
    .id_tag    (id_tag),
    .stage_tag (stage_tag)
  );

  assign rs1_used = bus.i_id_valid && bus.i_id_rs1_hazard_on;
  assign rs2_used = bus.i_id_valid && bus.i_id_rs2_hazard_on;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_match
      assign hit_a[gi] = rs1_used && tag_writes(stage_tag[gi], bus.i_id_rs1);
      assign hit_b[gi] = rs2_used && tag_writes(stage_tag[gi], bus.i_id_rs2);
    end

    if (FWD_EN != 0) begin : g_fwd
      // Load data only exists at the end of MEM, so a reader right behind a
      // load must wait one cycle; every other case is covered by a bypass.
      assign raw_stall = (hit_a[STG_EX] || hit_b[STG_EX]) && stage_tag[STG_EX].load;
    end else begin : g_interlock
      assign raw_stall = |{hit_a, hit_b};
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    pipe_en       = 1'b0;
    shift_en      = 1'b0;
    insert_bubble = 1'b0;
    stall_hit     = 1'b0;
    flush_hit     = 1'b0;
    fwd_a_next    = fwd_a_reg;
    fwd_b_next    = fwd_b_reg;

    case (state_reg)
      RESET: state_next = RUN;
      RUN: begin
        if (bus.i_mem_stall) begin
          // Whole pipe frozen. EX keeps its instruction, so a taken branch
          // there is still asserted and gets serviced once the stall lifts.
        end else if (bus.i_ex_br_taken) begin
          // Redirect squashes whatever was in ID, including a would-be
          // stall, so that stall is neither applied nor counted.
          pc_en         = 1'b1;
          ifid_en       = 1'b1;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
          pipe_en       = 1'b1;
          shift_en      = 1'b1;
          insert_bubble = 1'b1;
          fwd_a_next    = FWD_RF;
          fwd_b_next    = FWD_RF;
          flush_hit     = 1'b1;
        end else if (raw_stall) begin
          idex_flush    = 1'b1;
          pipe_en       = 1'b1;
          shift_en      = 1'b1;
          insert_bubble = 1'b1;
          fwd_a_next    = FWD_RF;
          fwd_b_next    = FWD_RF;
          stall_hit     = 1'b1;
        end else begin
          pc_en         = 1'b1;
          ifid_en       = 1'b1;
          pipe_en       = 1'b1;
          shift_en      = 1'b1;
          fwd_a_next    = (FWD_EN != 0) ? fwd_pick(hit_a) : FWD_RF;
          fwd_b_next    = (FWD_EN != 0) ? fwd_pick(hit_b) : FWD_RF;
        end
      end
      default: state_next = RESET;
    endcase
  end

  assign stall_cnt_next = (stall_hit && (stall_cnt_reg != CNT_MAX))
                        ? stall_cnt_reg + CNT_W'(1) : stall_cnt_reg;
  assign flush_cnt_next = (flush_hit && (flush_cnt_reg != CNT_MAX))
                        ? flush_cnt_reg + CNT_W'(1) : flush_cnt_reg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= RESET;
      fwd_a_reg     <= FWD_RF;
      fwd_b_reg     <= FWD_RF;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      fwd_a_reg     <= fwd_a_next;
      fwd_b_reg     <= fwd_b_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign bus.o_pc_en      = pc_en;
  assign bus.o_ifid_en    = ifid_en;
  assign bus.o_ifid_flush = ifid_flush;
  assign bus.o_idex_flush = idex_flush;
  assign bus.o_pipe_en    = pipe_en;
  assign bus.o_fwd_a_sel  = fwd_a_reg;
  assign bus.o_fwd_b_sel  = fwd_b_reg;
  assign bus.o_stall_cnt  = stall_cnt_reg;
  assign bus.o_flush_cnt  = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios against two controllers sharing a clock:
// dut (forwarding on, 32-bit counters) and dut_nf (interlock only, 4-bit
// counters so saturation is reachable).
module tb_hazard_ctrl;

  // Control vector order: {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en}
  localparam logic [4:0] EN_OFF   = 5'b00000;
  localparam logic [4:0] EN_RUN   = 5'b11001;
  localparam logic [4:0] EN_STALL = 5'b00011;
  localparam logic [4:0] EN_REDIR = 5'b11111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  int   exp_stall_nf = 0;

  hazard_ctrl_if #(.CNT_W(32)) bus ();
  hazard_ctrl_if #(.CNT_W(4))  bus_nf ();

  hazard_ctrl #(.FWD_EN(1), .CNT_W(32)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  hazard_ctrl #(.FWD_EN(0), .CNT_W(4)) dut_nf (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus_nf)
  );

  always #5 clk = ~clk;

  logic [4:0] ctl, ctl_nf;
  assign ctl    = {bus.o_pc_en, bus.o_ifid_en, bus.o_ifid_flush, bus.o_idex_flush, bus.o_pipe_en};
  assign ctl_nf = {bus_nf.o_pc_en, bus_nf.o_ifid_en, bus_nf.o_ifid_flush,
                   bus_nf.o_idex_flush, bus_nf.o_pipe_en};

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_id(input bit nf, input logic v, input logic [4:0] rs1, input logic h1,
                        input logic [4:0] rs2, input logic h2, input logic [4:0] rd,
                        input logic we, input logic ld);
    if (!nf) begin
      bus.i_id_valid = v;  bus.i_id_rs1 = rs1; bus.i_id_rs1_hazard_on = h1;
      bus.i_id_rs2 = rs2;  bus.i_id_rs2_hazard_on = h2;
      bus.i_id_rd = rd;    bus.i_id_reg_wren = we; bus.i_id_is_load = ld;
    end else begin
      bus_nf.i_id_valid = v;  bus_nf.i_id_rs1 = rs1; bus_nf.i_id_rs1_hazard_on = h1;
      bus_nf.i_id_rs2 = rs2;  bus_nf.i_id_rs2_hazard_on = h2;
      bus_nf.i_id_rd = rd;    bus_nf.i_id_reg_wren = we; bus_nf.i_id_is_load = ld;
    end
  endtask

  task automatic drain(input bit nf);
    set_id(nf, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.i_ex_br_taken = 0; bus.i_mem_stall = 0;
    bus_nf.i_ex_br_taken = 0; bus_nf.i_mem_stall = 0;
    rst_n = 0;
    repeat (2) tick();
    settle();
    total++; if (ctl !== EN_OFF) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, EN_OFF); end
    total++; if (bus.o_fwd_a_sel !== 2'b00 || bus.o_fwd_b_sel !== 2'b00) begin bad++; $display("FAIL reset_fwd got=%b/%b exp=00/00", bus.o_fwd_a_sel, bus.o_fwd_b_sel); end
    total++; if (bus.o_stall_cnt !== 32'd0 || bus.o_flush_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.o_stall_cnt, bus.o_flush_cnt); end
    tick();
    rst_n = 1;
    settle();
    total++; if (ctl !== EN_OFF) begin bad++; $display("FAIL release_first_cycle got=%b exp=%b", ctl, EN_OFF); end
    total++; if (ctl_nf !== EN_OFF) begin bad++; $display("FAIL release_first_cycle_nf got=%b exp=%b", ctl_nf, EN_OFF); end
    tick();
    settle();
    total++; if (ctl !== EN_RUN) begin bad++; $display("FAIL release_run got=%b exp=%b", ctl, EN_RUN); end
    total++; if (ctl_nf !== EN_RUN) begin bad++; $display("FAIL release_run_nf got=%b exp=%b", ctl_nf, EN_RUN); end
    tick();
    $display("[reset] ctl=%b ctl_nf=%b", ctl, ctl_nf);
  endtask

  task automatic test_load_use();
    drain(0);
    set_id(0, 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);          // lw x5, 0(x1)
    settle();
    total++; if (ctl !== EN_RUN) begin bad++; $display("FAIL lu_lw_issue got=%b exp=%b", ctl, EN_RUN); end
    tick();
    set_id(0, 1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);          // add x6, x5, x7
    settle();
    total++; if (ctl !== EN_STALL) begin bad++; $display("FAIL lu_stall got=%b exp=%b", ctl, EN_STALL); end
    tick();
    exp_stall++;
    settle();
    total++; if (ctl !== EN_RUN) begin bad++; $display("FAIL lu_resume got=%b exp=%b", ctl, EN_RUN); end
    total++; if (bus.o_stall_cnt !== 32'(exp_stall)) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", bus.o_stall_cnt, exp_stall); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    total++; if (bus.o_fwd_a_sel !== 2'b10 || bus.o_fwd_b_sel !== 2'b00) begin bad++; $display("FAIL lu_fwd got=%b/%b exp=10/00", bus.o_fwd_a_sel, bus.o_fwd_b_sel); end
    tick();
    $display("[load_use] stall_cnt=%0d fwd=%b/%b", bus.o_stall_cnt, bus.o_fwd_a_sel, bus.o_fwd_b_sel);
  endtask

  task automatic test_fwd_paths();
    logic [1:0] exp_sel [3];
    exp_sel[0] = 2'b01; exp_sel[1] = 2'b10; exp_sel[2] = 2'b11;
    for (int gap = 0; gap < 3; gap++) begin
      drain(0);
      set_id(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);        // add x3, x1, x2
      tick();
      for (int k = 0; k < gap; k++) begin
        set_id(0, 1, 5'd1, 1, 5'd2, 1, 5'd8, 1, 0);      // add x8, x1, x2
        tick();
      end
      set_id(0, 1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);        // sub x4, x3, x3
      settle();
      total++; if (ctl !== EN_RUN) begin bad++; $display("FAIL fwd_gap%0d_nostall got=%b exp=%b", gap, ctl, EN_RUN); end
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      total++; if (bus.o_fwd_a_sel !== exp_sel[gap] || bus.o_fwd_b_sel !== exp_sel[gap]) begin bad++; $display("FAIL fwd_gap%0d got=%b/%b exp=%b/%b", gap, bus.o_fwd_a_sel, bus.o_fwd_b_sel, exp_sel[gap], exp_sel[gap]); end
      tick();
      $display("[fwd_gap%0d] fwd=%b/%b", gap, bus.o_fwd_a_sel, bus.o_fwd_b_sel);
    end
    // Two writers of x3 in flight: the younger (EX) wins; rs2 not read.
    drain(0);
    set_id(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    tick();
    set_id(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    tick();
    set_id(0, 1, 5'd3, 1, 5'd3, 0, 5'd4, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    total++; if (bus.o_fwd_a_sel !== 2'b01 || bus.o_fwd_b_sel !== 2'b00) begin bad++; $display("FAIL fwd_youngest got=%b/%b exp=01/00", bus.o_fwd_a_sel, bus.o_fwd_b_sel); end
    tick();
    $display("[fwd_youngest] fwd=%b/%b", bus.o_fwd_a_sel, bus.o_fwd_b_sel);
  endtask

  task automatic test_x0();
    drain(0);
    set_id(0, 1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1);          // lw x0, 0(x1)
    tick();
    set_id(0, 1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0);          // add x9, x0, x0
    settle();
    total++; if (ctl !== EN_RUN) begin bad++; $display("FAIL x0_nostall got=%b exp=%b", ctl, EN_RUN); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    total++; if (bus.o_fwd_a_sel !== 2'b00 || bus.o_fwd_b_sel !== 2'b00) begin bad++; $display("FAIL x0_fwd got=%b/%b exp=00/00", bus.o_fwd_a_sel, bus.o_fwd_b_sel); end
    tick();
    $display("[x0] ctl=%b fwd=%b/%b", ctl, bus.o_fwd_a_sel, bus.o_fwd_b_sel);
  endtask

  task automatic test_redirect();
    drain(0);
    set_id(0, 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);          // lw x5
    tick();
    set_id(0, 1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);          // add x6, x5, x7
    bus.i_ex_br_taken = 1;
    settle();
    total++; if (ctl !== EN_REDIR) begin bad++; $display("FAIL redir_ctl got=%b exp=%b", ctl, EN_REDIR); end
    tick();
    exp_flush++;
    bus.i_ex_br_taken = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    total++; if (bus.o_flush_cnt !== 32'(exp_flush)) begin bad++; $display("FAIL redir_flush_cnt got=%0d exp=%0d", bus.o_flush_cnt, exp_flush); end
    total++; if (bus.o_stall_cnt !== 32'(exp_stall)) begin bad++; $display("FAIL redir_stall_cnt got=%0d exp=%0d", bus.o_stall_cnt, exp_stall); end
    total++; if (ctl !== EN_RUN) begin bad++; $display("FAIL redir_after got=%b exp=%b", ctl, EN_RUN); end
    tick();
    $display("[redirect] flush_cnt=%0d stall_cnt=%0d", bus.o_flush_cnt, bus.o_stall_cnt);
  endtask

  task automatic test_freeze();
    drain(0);
    set_id(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);          // add x3, x1, x2
    tick();
    set_id(0, 1, 5'd3, 1, 5'd0, 0, 5'd5, 1, 1);          // lw x5, 0(x3)
    tick();
    set_id(0, 1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);          // add x6, x5, x7
    bus.i_mem_stall = 1;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++; if (ctl !== EN_OFF) begin bad++; $display("FAIL frz%0d_ctl got=%b exp=%b", c, ctl, EN_OFF); end
      total++; if (bus.o_fwd_a_sel !== 2'b01 || bus.o_stall_cnt !== 32'(exp_stall)) begin bad++; $display("FAIL frz%0d_hold fwd_a=%b stall=%0d exp 01/%0d", c, bus.o_fwd_a_sel, bus.o_stall_cnt, exp_stall); end
      tick();
    end
    bus.i_mem_stall = 0;
    settle();
    total++; if (ctl !== EN_STALL) begin bad++; $display("FAIL frz_release_stall got=%b exp=%b", ctl, EN_STALL); end
    tick();
    exp_stall++;
    settle();
    total++; if (ctl !== EN_RUN || bus.o_fwd_a_sel !== 2'b00) begin bad++; $display("FAIL frz_resume ctl=%b fwd_a=%b exp %b/00", ctl, bus.o_fwd_a_sel, EN_RUN); end
    total++; if (bus.o_stall_cnt !== 32'(exp_stall)) begin bad++; $display("FAIL frz_stall_cnt got=%0d exp=%0d", bus.o_stall_cnt, exp_stall); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    total++; if (bus.o_fwd_a_sel !== 2'b10 || bus.o_fwd_b_sel !== 2'b00) begin bad++; $display("FAIL frz_fwd got=%b/%b exp=10/00", bus.o_fwd_a_sel, bus.o_fwd_b_sel); end
    tick();
    $display("[freeze] stall_cnt=%0d fwd=%b/%b", bus.o_stall_cnt, bus.o_fwd_a_sel, bus.o_fwd_b_sel);
  endtask

  task automatic test_interlock();
    drain(1);
    set_id(1, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);          // add x3, x1, x2
    settle();
    total++; if (ctl_nf !== EN_RUN) begin bad++; $display("FAIL il_issue got=%b exp=%b", ctl_nf, EN_RUN); end
    tick();
    set_id(1, 1, 5'd3, 1, 5'd4, 1, 5'd4, 1, 0);          // add x4, x3, x4
    for (int c = 0; c < 3; c++) begin
      settle();
      total++; if (ctl_nf !== EN_STALL) begin bad++; $display("FAIL il_stall%0d got=%b exp=%b", c, ctl_nf, EN_STALL); end
      tick();
      exp_stall_nf++;
    end
    settle();
    total++; if (ctl_nf !== EN_RUN) begin bad++; $display("FAIL il_resume got=%b exp=%b", ctl_nf, EN_RUN); end
    tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    total++; if (bus_nf.o_stall_cnt !== 4'(exp_stall_nf)) begin bad++; $display("FAIL il_stall_cnt got=%0d exp=%0d", bus_nf.o_stall_cnt, exp_stall_nf); end
    total++; if (bus_nf.o_fwd_a_sel !== 2'b00 || bus_nf.o_fwd_b_sel !== 2'b00) begin bad++; $display("FAIL il_fwd got=%b/%b exp=00/00", bus_nf.o_fwd_a_sel, bus_nf.o_fwd_b_sel); end
    tick();
    $display("[interlock] stall_cnt=%0d", bus_nf.o_stall_cnt);
  endtask

  task automatic test_saturate();
    bus_nf.i_ex_br_taken = 1;
    settle();
    total++; if (ctl_nf !== EN_REDIR) begin bad++; $display("FAIL sat_ctl got=%b exp=%b", ctl_nf, EN_REDIR); end
    repeat (14) tick();
    settle();
    total++; if (bus_nf.o_flush_cnt !== 4'hE) begin bad++; $display("FAIL sat_count14 got=%0d exp=14", bus_nf.o_flush_cnt); end
    repeat (3) tick();
    bus_nf.i_ex_br_taken = 0;
    settle();
    total++; if (bus_nf.o_flush_cnt !== 4'hF) begin bad++; $display("FAIL sat_hold got=%0d exp=15", bus_nf.o_flush_cnt); end
    total++; if (bus_nf.o_stall_cnt !== 4'(exp_stall_nf)) begin bad++; $display("FAIL sat_stall_cnt got=%0d exp=%0d", bus_nf.o_stall_cnt, exp_stall_nf); end
    tick();
    $display("[saturate] flush_cnt=%0d", bus_nf.o_flush_cnt);
  endtask

  task automatic test_reset_mid();
    drain(0);
    set_id(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);          // add x3
    tick();
    set_id(0, 1, 5'd3, 1, 5'd0, 0, 5'd5, 1, 1);          // lw x5, 0(x3)
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (bus.o_fwd_a_sel !== 2'b01) begin bad++; $display("FAIL rm_pre_fwd got=%b exp=01", bus.o_fwd_a_sel); end
    rst_n = 0;
    settle();
    total++; if (ctl !== EN_OFF || bus.o_fwd_a_sel !== 2'b00) begin bad++; $display("FAIL rm_clear ctl=%b fwd_a=%b exp %b/00", ctl, bus.o_fwd_a_sel, EN_OFF); end
    total++; if (bus.o_stall_cnt !== 32'd0 || bus.o_flush_cnt !== 32'd0 || bus_nf.o_flush_cnt !== 4'd0) begin bad++; $display("FAIL rm_cnt got=%0d/%0d/%0d exp=0/0/0", bus.o_stall_cnt, bus.o_flush_cnt, bus_nf.o_flush_cnt); end
    tick();
    rst_n = 1;
    set_id(0, 1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);          // reader of the discarded load
    settle();
    total++; if (ctl !== EN_OFF) begin bad++; $display("FAIL rm_reset_state got=%b exp=%b", ctl, EN_OFF); end
    tick();
    settle();
    total++; if (ctl !== EN_RUN) begin bad++; $display("FAIL rm_shadow_cleared got=%b exp=%b", ctl, EN_RUN); end
    tick();
    $display("[reset_mid] ctl=%b stall_cnt=%0d", ctl, bus.o_stall_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_fwd_paths();
    test_x0();
    test_redirect();
    test_freeze();
    test_interlock();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
